// File: rtl/calc_run_sequencer_pkg.sv
// Shared definitions for the calculation run sequencer.
//   - run_state_t : FSM state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3, ERR=4)
//   - *_DEF       : default parameter values for the sequencer
//   - VALUE_W     : operand / result magnitude width
//   - tick_width(): width of the saturating LOAD/RUN tick counter
package calc_run_sequencer_pkg;

  localparam int VALUE_W           = 30;
  localparam int CPU_DIV_DEF       = 4;
  localparam int RST_TICKS_DEF     = 4;
  localparam int TIMEOUT_TICKS_DEF = 4096;
  localparam int DEB_CYC_DEF       = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } run_state_t;

  // Enough bits to hold the larger of the two tick limits.
  function automatic int tick_width(input int rst_ticks, input int timeout_ticks);
    int top_val;
    top_val = (rst_ticks > timeout_ticks) ? rst_ticks : timeout_ticks;
    return (top_val < 1) ? 1 : $clog2(top_val + 1);
  endfunction

endpackage

// File: rtl/calc_run_sequencer_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and
// rising-edge pulse on the debounced level.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   btn_async   in   raw button, asynchronous to clk
//   press_pulse out  1-cycle pulse when the debounced level rises
module btn_debounce #(
  parameter int DEB_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_async,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC);

  logic             sync1_reg;
  logic             sync2_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             level_reg;
  logic             level_next;
  logic             level_dly_reg;

  // Count consecutive high samples; the counter parks at DEB_CYC so a long
  // hold never wraps back and re-fires the edge detector.
  always_comb begin
    cnt_next   = cnt_reg;
    level_next = level_reg;
    if (!sync2_reg) begin
      cnt_next   = '0;
      level_next = 1'b0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + 1'b1;
      if (cnt_reg == CNT_MAX - 1'b1) begin
        level_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      cnt_reg       <= '0;
      level_reg     <= 1'b0;
      level_dly_reg <= 1'b0;
    end else begin
      sync1_reg     <= btn_async;
      sync2_reg     <= sync1_reg;
      cnt_reg       <= cnt_next;
      level_reg     <= level_next;
      level_dly_reg <= level_reg;
    end
  end

  assign press_pulse = level_reg & ~level_dly_reg;

endmodule

// File: rtl/calc_run_sequencer.sv
// Sequences one calculation run of the embedded CPU: captures the operand,
// holds the CPU in reset for RST_TICKS CPU ticks, runs it until it reports
// done or TIMEOUT_TICKS ticks elapse, then latches the result.
// Ports:
//   clock        in   system clock
//   rst          in   asynchronous active-low reset
//   go_btn       in   raw start button (asynchronous)
//   sign_in      in   operand sign from the input path
//   value_in     in   operand magnitude
//   cpu_done     in   CPU result-ready flag
//   cpu_sign     in   CPU result sign
//   cpu_value    in   CPU result magnitude
//   cpu_rst      out  active-high CPU reset
//   cpu_ce       out  CPU clock enable, 1-cycle pulse every CPU_DIV clocks
//   op_sign      out  captured operand sign
//   op_value     out  captured operand magnitude
//   res_sign     out  latched result sign
//   res_value    out  latched result magnitude
//   res_valid    out  result valid (sticky until next accepted go)
//   busy         out  run in progress
//   timeout_err  out  last run aborted (sticky until next accepted go)
module calc_run_sequencer
  import calc_run_sequencer_pkg::*;
#(
  parameter int CPU_DIV       = CPU_DIV_DEF,
  parameter int RST_TICKS     = RST_TICKS_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int DEB_CYC       = DEB_CYC_DEF
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               go_btn,
  input  logic               sign_in,
  input  logic [VALUE_W-1:0] value_in,
  input  logic               cpu_done,
  input  logic               cpu_sign,
  input  logic [VALUE_W-1:0] cpu_value,
  output logic               cpu_rst,
  output logic               cpu_ce,
  output logic               op_sign,
  output logic [VALUE_W-1:0] op_value,
  output logic               res_sign,
  output logic [VALUE_W-1:0] res_value,
  output logic               res_valid,
  output logic               busy,
  output logic               timeout_err
);

  localparam int DIV_W  = $clog2(CPU_DIV);
  localparam int TICK_W = tick_width(RST_TICKS, TIMEOUT_TICKS);

  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CPU_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_SAT    = '1;
  localparam logic [TICK_W-1:0] RST_LIM     = TICK_W'(RST_TICKS);
  localparam logic [TICK_W-1:0] TIMEOUT_LIM = TICK_W'(TIMEOUT_TICKS);

  logic               go;
  logic [DIV_W-1:0]   div_cnt_reg;
  run_state_t         state_reg;
  run_state_t         state_next;
  logic [TICK_W-1:0]  tick_reg;
  logic [TICK_W-1:0]  tick_next;
  logic [TICK_W-1:0]  tick_inc;
  logic               capture_op;
  logic               latch_res;
  logic               set_err;

  logic               op_sign_reg;
  logic [VALUE_W-1:0] op_value_reg;
  logic               res_sign_reg;
  logic [VALUE_W-1:0] res_value_reg;
  logic               res_valid_reg;
  logic               timeout_err_reg;

  btn_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_go_debounce (
    .clk         (clock),
    .rst_n       (rst),
    .btn_async   (go_btn),
    .press_pulse (go)
  );

  // Free-running CPU clock-enable divider; it never stops so the CPU tick
  // phase is independent of the FSM.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      div_cnt_reg <= '0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign cpu_ce = (div_cnt_reg == DIV_LAST);

  // Saturating increment: the tick counter never wraps.
  assign tick_inc = (tick_reg == TICK_SAT) ? tick_reg : tick_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    capture_op = 1'b0;
    latch_res  = 1'b0;
    set_err    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (go) begin
          capture_op = 1'b1;
          tick_next  = '0;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Leave on the edge of the RST_TICKS-th tick so the CPU sees reset
        // on exactly RST_TICKS enabled edges.
        if (cpu_ce) begin
          if (tick_inc >= RST_LIM) begin
            tick_next  = '0;
            state_next = ST_RUN;
          end else begin
            tick_next = tick_inc;
          end
        end
      end
      ST_RUN: begin
        // Done is checked before the timeout so a result on the final
        // allowed tick is still accepted.
        if (cpu_ce) begin
          if (cpu_done) begin
            state_next = ST_DONE;
          end else begin
            tick_next = tick_inc;
            if (tick_inc >= TIMEOUT_LIM) begin
              state_next = ST_ERR;
            end
          end
        end
      end
      ST_DONE: begin
        latch_res  = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        set_err    = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      tick_reg  <= '0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      op_sign_reg     <= 1'b0;
      op_value_reg    <= '0;
      res_sign_reg    <= 1'b0;
      res_value_reg   <= '0;
      res_valid_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (capture_op) begin
        op_sign_reg     <= sign_in;
        op_value_reg    <= value_in;
        res_valid_reg   <= 1'b0;
        timeout_err_reg <= 1'b0;
      end
      if (latch_res) begin
        res_sign_reg  <= cpu_sign;
        res_value_reg <= cpu_value;
        res_valid_reg <= 1'b1;
      end
      if (set_err) begin
        timeout_err_reg <= 1'b1;
      end
    end
  end

  // The CPU is held in reset everywhere except RUN, which also covers the
  // asynchronous reset case since the state register clears to IDLE.
  assign cpu_rst     = (state_reg != ST_RUN);
  assign busy        = (state_reg != ST_IDLE);
  assign op_sign     = op_sign_reg;
  assign op_value    = op_value_reg;
  assign res_sign    = res_sign_reg;
  assign res_value   = res_value_reg;
  assign res_valid   = res_valid_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_calc_run_sequencer.sv
module tb_calc_run_sequencer;

  localparam int CPU_DIV       = 4;
  localparam int RST_TICKS     = 4;
  localparam int TIMEOUT_TICKS = 4096;
  localparam int DEB_CYC       = 16;

  logic        clock;
  logic        rst;
  logic        go_btn;
  logic        sign_in;
  logic [29:0] value_in;
  logic        cpu_done;
  logic        cpu_sign;
  logic [29:0] cpu_value;
  logic        cpu_rst;
  logic        cpu_ce;
  logic        op_sign;
  logic [29:0] op_value;
  logic        res_sign;
  logic [29:0] res_value;
  logic        res_valid;
  logic        busy;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  calc_run_sequencer #(
    .CPU_DIV       (CPU_DIV),
    .RST_TICKS     (RST_TICKS),
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .DEB_CYC       (DEB_CYC)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .go_btn      (go_btn),
    .sign_in     (sign_in),
    .value_in    (value_in),
    .cpu_done    (cpu_done),
    .cpu_sign    (cpu_sign),
    .cpu_value   (cpu_value),
    .cpu_rst     (cpu_rst),
    .cpu_ce      (cpu_ce),
    .op_sign     (op_sign),
    .op_value    (op_value),
    .res_sign    (res_sign),
    .res_value   (res_value),
    .res_valid   (res_valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Test CPU: returns the low 30 bits of the operand squared with the sign
  // inverted, computed from whatever operand the sequencer hands it.
  assign cpu_value = op_value * op_value;
  assign cpu_sign  = ~op_sign;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        sign;
    logic [29:0] value;
    int          done_at;   // RUN tick on which cpu_done is seen high, 0 = never
    bit          early;     // cpu_done already high from the button press
    bit          exp_valid;
    bit          exp_err;
    logic        exp_rsign;
    logic [29:0] exp_rvalue;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [29:0] sq30(input logic [29:0] v);
    longint p;
    p = longint'(v) * longint'(v);
    return p[29:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  // The divider phase is checked against a count of edges since reset.
  task automatic step();
    @(posedge clock);
    #1;
    if (rst) begin
      edge_cnt++;
      check("cpu_ce_phase", cpu_ce, 64'((edge_cnt % CPU_DIV) == CPU_DIV - 1));
    end else begin
      check("cpu_ce_in_reset", cpu_ce, 0);
    end
  endtask

  task automatic start_run(input logic sign, input logic [29:0] value,
                           input int min_steps, input bit early);
    int n;
    bit found;
    n = 0;
    found = 0;
    sign_in  = sign;
    value_in = value;
    cpu_done = early;
    go_btn   = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (busy) begin
        n = i;
        found = 1;
        break;
      end
    end
    check("go_detect", found, 1);
    check("go_not_before_debounce", 64'(n >= min_steps), 1);
    check("op_sign_capture", op_sign, sign);
    check("op_value_capture", op_value, value);
    check("load_cpu_rst", cpu_rst, 1);
    check("go_clears_valid", res_valid, 0);
    check("go_clears_err", timeout_err, 0);
    go_btn   = 1'b0;
    value_in = ~value;
    sign_in  = ~sign;
  endtask

  task automatic finish_run(input logic sign, input logic [29:0] value, input int done_at,
                            input bit early, input bit repress, input bit exp_valid,
                            input bit exp_err, input logic exp_rsign,
                            input logic [29:0] exp_rvalue, input int idle_steps);
    int load_ticks;
    int run_ticks;
    bit ended;
    bit seen_busy;
    load_ticks = 0;
    for (int i = 0; i < (RST_TICKS + 2) * CPU_DIV && cpu_rst; i++) begin
      if (cpu_ce) load_ticks++;
      step();
    end
    check("rst_ticks", load_ticks, RST_TICKS);
    check("cpu_rst_release", cpu_rst, 0);

    run_ticks = 0;
    ended = 0;
    for (int i = 0; i < (TIMEOUT_TICKS + 4) * CPU_DIV && !ended; i++) begin
      cpu_done = early || (done_at != 0 && run_ticks >= done_at - 1);
      go_btn   = repress && run_ticks >= 1 && run_ticks <= 12;
      if (repress && run_ticks >= 1) value_in = 30'd7;
      check("cpu_rst_in_run", cpu_rst, 0);
      if (cpu_ce) begin
        run_ticks++;
        if (cpu_done) ended = 1;
        else if (run_ticks == TIMEOUT_TICKS) ended = 1;
      end
      step();
    end
    go_btn = 1'b0;
    check("run_end_reached", ended, 1);
    check("wrapup_cpu_rst", cpu_rst, 1);
    check("wrapup_valid_not_yet", res_valid, 0);
    check("wrapup_err_not_yet", timeout_err, 0);
    step();
    cpu_done = 1'b0;
    check("res_valid", res_valid, exp_valid);
    check("timeout_err", timeout_err, exp_err);
    check("res_value", res_value, exp_rvalue);
    check("res_sign", res_sign, exp_rsign);
    check("idle_busy", busy, 0);
    check("idle_cpu_rst", cpu_rst, 1);
    check("op_value_held", op_value, value);
    check("op_sign_held", op_sign, sign);
    seen_busy = 0;
    for (int i = 0; i < idle_steps; i++) begin
      step();
      if (busy) seen_busy = 1;
    end
    check("no_restart", seen_busy, 0);
    check("res_valid_sticky", res_valid, exp_valid);
    check("timeout_err_sticky", timeout_err, exp_err);
    $display("run value=%0d sign=%0d done_at=%0d -> res_valid=%0d err=%0d res=%0d/%0d",
             value, sign, done_at, res_valid, timeout_err, res_sign, res_value);
  endtask

  initial begin
    bit seen_busy;
    logic [29:0] v;
    logic        s;
    int          d;
    bit          rep;

    vecs[0] = '{1'b1, 30'd12345,      7,    1'b0, 1'b1, 1'b0, 1'b0, 30'd152399025};
    vecs[1] = '{1'b0, 30'd99,         0,    1'b0, 1'b0, 1'b1, 1'b0, 30'd152399025};
    vecs[2] = '{1'b0, 30'd5,          4096, 1'b0, 1'b1, 1'b0, 1'b1, 30'd25};
    vecs[3] = '{1'b1, 30'h3FFF_FFFF,  1,    1'b1, 1'b1, 1'b0, 1'b0, 30'd1};

    rst      = 1'b0;
    go_btn   = 1'b0;
    sign_in  = 1'b0;
    value_in = '0;
    cpu_done = 1'b0;
    repeat (3) step();
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_op_value", op_value, 0);
    check("rst_op_sign", op_sign, 0);
    check("rst_res_value", res_value, 0);
    check("rst_res_sign", res_sign, 0);
    rst = 1'b1;
    edge_cnt = 0;
    repeat (5) step();

    // Table-driven runs: normal result, timeout, done on the last tick,
    // done already high during LOAD.
    for (int k = 0; k < 4; k++) begin
      start_run(vecs[k].sign, vecs[k].value, DEB_CYC, vecs[k].early);
      finish_run(vecs[k].sign, vecs[k].value, vecs[k].done_at, vecs[k].early, 1'b0,
                 vecs[k].exp_valid, vecs[k].exp_err, vecs[k].exp_rsign,
                 vecs[k].exp_rvalue, 8);
    end

    // Reset asserted while the CPU is running.
    start_run(1'b1, 30'd555, DEB_CYC, 1'b0);
    for (int i = 0; i < 40 && cpu_rst; i++) step();
    repeat (3) step();
    check("pre_reset_in_run", cpu_rst, 0);
    rst = 1'b0;
    #1;
    check("mid_reset_cpu_rst", cpu_rst, 1);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_res_valid", res_valid, 0);
    check("mid_reset_timeout_err", timeout_err, 0);
    check("mid_reset_op_value", op_value, 0);
    check("mid_reset_res_value", res_value, 0);
    check("mid_reset_cpu_ce", cpu_ce, 0);
    repeat (2) step();
    rst = 1'b1;
    edge_cnt = 0;
    step();
    check("post_reset_idle_busy", busy, 0);
    check("post_reset_idle_cpu_rst", cpu_rst, 1);
    $display("reset in RUN -> cpu_rst=%0d busy=%0d res_valid=%0d", cpu_rst, busy, res_valid);

    // Bouncing button: 10 high, 1 low, 10 high must not start a run.
    seen_busy = 0;
    go_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); if (busy) seen_busy = 1; end
    go_btn = 1'b0;
    step();
    if (busy) seen_busy = 1;
    go_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); if (busy) seen_busy = 1; end
    check("bounce_no_go", seen_busy, 0);
    $display("bounce -> busy seen=%0d", seen_busy);
    start_run(1'b0, 30'd4242, 1, 1'b0);
    finish_run(1'b0, 30'd4242, 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, sq30(30'd4242), 40);

    // Second press and operand change during RUN must not disturb the run.
    start_run(1'b1, 30'd12345, DEB_CYC, 1'b0);
    finish_run(1'b1, 30'd12345, 30, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'd152399025, 60);

    // Randomised runs checked against the squaring reference.
    for (int k = 0; k < 6; k++) begin
      v   = 30'($urandom);
      s   = 1'($urandom_range(0, 1));
      d   = int'($urandom_range(1, 40));
      rep = (d > 14) && ($urandom_range(0, 1) == 1);
      start_run(s, v, DEB_CYC, 1'b0);
      finish_run(s, v, d, 1'b0, rep, 1'b1, 1'b0, ~s, sq30(v), 40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_run_sequencer.md
Name: calc_run_sequencer

Overview:
- Sequences one calculation run of the embedded CPU: captures the operand from the input path, holds the CPU in reset, releases it, waits for completion or timeout, then latches the result for the BCD conversion and VGA path.
- Replaces the free-running CPU clock divider and the start pulse logic with a single-clock controller.
- The CPU is clocked by `clock` and advances only when `cpu_ce` is high.

Parameters:
- CPU_DIV, 4: `clock` cycles per `cpu_ce` pulse; must be ≥2.
- RST_TICKS, 4: `cpu_ce` ticks for which `cpu_rst` is held during LOAD.
- TIMEOUT_TICKS, 4096: maximum `cpu_ce` ticks in RUN before abort.
- DEB_CYC, 16: `clock` cycles the synced button must be stable high; use 1_000_000 on the board.

Ports:
- clock  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- go_btn  in  1  raw start button, asynchronous to `clock`
- sign_in  in  1  operand sign from the input path
- value_in  in  30  operand magnitude (decimal integer)
- cpu_done  in  1  CPU result-ready flag
- cpu_sign  in  1  CPU result sign
- cpu_value  in  30  CPU result magnitude
- cpu_rst  out  1  active-high CPU reset
- cpu_ce  out  1  CPU clock enable, 1-cycle pulse
- op_sign  out  1  captured operand sign to CPU
- op_value  out  30  captured operand to CPU
- res_sign  out  1  latched result sign
- res_value  out  30  latched result magnitude
- res_valid  out  1  result valid
- busy  out  1  run in progress
- timeout_err  out  1  last run aborted

Behaviour:
- Reset (`rst`=0, asynchronous) drives the following; FSM goes to IDLE.
  - All counters are cleared.
  - `cpu_rst`=1, `cpu_ce`=0.
  - `op_*`, `res_*`, `res_valid`, `busy` and `timeout_err` are all 0.
- Release of reset is synchronous.
- Divider: counter 0..CPU_DIV-1, free-running in every state. `cpu_ce`=1 in the cycle where the count equals CPU_DIV-1.
- Button path:
  - 2-flop synchronizer, then a stability counter.
  - The debounced level rises after DEB_CYC consecutive high samples; any low sample clears the counter.
  - `go` is a 1-cycle pulse on the rising edge of the debounced level.
- FSM states are IDLE, LOAD, RUN, DONE, ERR.
- IDLE:
  - `cpu_rst`=1, `busy`=0.
  - On `go`: capture `sign_in` and `value_in` into `op_sign` and `op_value` on the same edge, clear `res_valid` and `timeout_err`, clear the tick counter, go to LOAD.
- LOAD:
  - `cpu_rst`=1, `busy`=1.
  - The tick counter increments on `cpu_ce`.
  - When the tick counter reaches RST_TICKS, clear it and go to RUN.
- RUN:
  - `cpu_rst`=0, `busy`=1.
  - `cpu_done` is sampled only in cycles where `cpu_ce`=1.
  - If sampled high → DONE. The done check has priority over timeout on the same tick.
  - Otherwise the tick counter increments; at TIMEOUT_TICKS → ERR.
- DONE: one cycle.
  - Latch `res_sign` and `res_value` from the CPU and set `res_valid`=1.
  - `cpu_rst`=1, then go to IDLE.
- ERR: one cycle.
  - `timeout_err`=1, `res_valid` stays 0, `res_*` hold their previous values.
  - `cpu_rst`=1, then go to IDLE.
- Latency:
  - `go` to the `cpu_rst` fall is RST_TICKS `cpu_ce` ticks.
  - A sampled `cpu_done` tick to `res_valid`=1 is 2 `clock` cycles (RUN→DONE edge, DONE registers).
- `res_valid` and `timeout_err` are sticky until the next accepted `go` or reset.
- `go` in any state other than IDLE is ignored. The operand is not recaptured, and the button must be released and re-debounced.
- `value_in` and `sign_in` changing after capture have no effect on the current run.
- `cpu_done` already high in LOAD is ignored; it is checked only in RUN.
- Width: the tick counter is ⌈log2(max(RST_TICKS, TIMEOUT_TICKS)+1)⌉ bits and saturates, never wraps. `res_value` passes 30 bits unchanged.

Decomposition:
- Shared package holds the state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3, ERR=4, 3 bits) and the default parameter constants.
- One sub-module, `btn_debounce` (synchronizer, stability counter, edge pulse), is natural and reusable for the other buttons.

Test Plan:
1. Reset while in RUN → same cycle `cpu_rst`=1, `busy`=0, `res_valid`=0, `timeout_err`=0. After release, FSM in IDLE.
2. `sign_in`=1, `value_in`=12345, hold `go_btn` 20 cycles → `op_value`=12345 and `op_sign`=1 latched. `cpu_rst` stays 1 for 4 ticks (16 clocks), then drops. CPU model asserts `cpu_done` with `cpu_value`=152399025, `cpu_sign`=0 → `res_valid`=1 and `res_value`=152399025 two clocks after the sampling tick.
3. Bouncing `go_btn` (high 10 clocks, low 1, high 10) → no `go`. A further high hold to 16 stable samples → exactly one run starts.
4. `cpu_done` never asserted → `timeout_err`=1 after 4096 RUN ticks, `res_valid`=0, `cpu_rst`=1, previous `res_value` unchanged.
5. Second button press during RUN, plus `value_in` changed to 7 → run unaffected, `op_value` stays 12345, no restart after DONE.
6. `cpu_done` asserted on exactly tick 4096 → DONE wins: `res_valid`=1, `timeout_err`=0.
